// File: rtl/alu_pkg.sv
// Shared ALU definitions: state encoding for the serial adder and its default width.
// No logic; constants and types only.
// Imported by serial_add_unit.
package alu_pkg;

  // One-bit state encoding for the serial adder control.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int ADD_WIDTH = 8;

endpackage

// File: rtl/serial_add_unit_badd.sv
// One-bit full adder cell (bAdd), the bit slice reused by the serial adder.
// Purely combinational, zero latency.
// No handshake; no backpressure.
module bAdd (
  input  logic A,
  input  logic B,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = A ^ B ^ c_in;
  assign c_out = (A & B) | (c_in & (A ^ B));

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder: one bAdd slice evaluated per clock, LSB first.
// Result and done appear WIDTH cycles after the accepting edge; one add per WIDTH+1 cycles.
// start is only sampled while idle; requests during busy are dropped, not queued.
module serial_add_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  // Holds the WIDTH-1 low result bits; the top bit comes straight from the
  // slice on the completing edge, so the register never needs a WIDTH-th slot.
  logic [WIDTH-2:0]   psum;
  logic               bit_sum;
  logic               bit_cout;

  bAdd u_badd (
    .A     (sh_a[0]),
    .B     (sh_b[0]),
    .c_in  (carry_q),
    .sum   (bit_sum),
    .c_out (bit_cout)
  );

  // Control FSM and datapath: accept in IDLE, shift one bit per cycle in RUN,
  // publish sum/c_out only on the final edge so partial bits are never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      sh_a    <= '0;
      sh_b    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      psum    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_a    <= a;
            sh_b    <= b;
            carry_q <= c_in;
            cnt     <= '0;
            psum    <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          carry_q <= bit_cout;
          psum    <= (psum >> 1) | ((WIDTH-1)'(bit_sum) << (WIDTH - 2));
          if (cnt == CNT_LAST) begin
            // Counter holds at its last value so it never wraps mid-operation.
            sum   <= {bit_sum, psum};
            c_out <= bit_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
